ddram_rom_loader: RTL

DDRAM_ROM_LOADER -- requirements
Module: ddram_rom_loader

---
 rtl/pgm_pkg.sv | 21 ++
 rtl/ioctl_skid.sv | 51 +++++
 rtl/ddram_rom_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pgm_pkg.sv
// Shared constants and state encoding for the DDRAM ROM loader.
// Lane/beat geometry matches a 16-bit HPS download port feeding 64-bit DDRAM beats.
package pgm_pkg;

   localparam int LANE_W = 16;
   localparam int BEAT_W = 64;
   localparam int BE_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_FLUSH   = 2'd3
   } ldr_state_e;

   // Byte-enable pair for one 16-bit lane of a little-endian 64-bit beat.
   function automatic logic [BE_W-1:0] lane_be(input logic [1:0] lane);
      return BE_W'(2'b11) << {lane, 1'b0};
   endfunction

endpackage

// File: rtl/ioctl_skid.sv
// One-entry skid buffer that holds a single ioctl strobe while the loader stalls.
// A push while already full is dropped; the HPS must honour ioctl_wait.
module ioctl_skid
   import pgm_pkg::*;
(
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [26:0]       push_addr,
   input  logic [LANE_W-1:0] push_data,
   output logic              valid,
   output logic [26:0]       addr,
   output logic [LANE_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [26:0]       addr_q, addr_d;
   logic [LANE_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (pop) begin
         valid_d = 1'b0;
      end
      if (push && !valid_q) begin
         valid_d = 1'b1;
         addr_d  = push_addr;
         data_d  = push_data;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign addr  = addr_q;
   assign data  = data_q;

endmodule

// File: rtl/ddram_rom_loader.sv
// Packs 16-bit HPS ioctl download halfwords into 64-bit DDRAM write beats.
// Partial beats are written with only the touched byte enables.
module ddram_rom_loader
   import pgm_pkg::*;
#(
   parameter logic [28:0] BASE_ADDR = 29'h0000000,
   parameter logic [7:0]  ROM_INDEX = 8'h00
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [26:0]       ioctl_addr,
   input  logic [LANE_W-1:0] ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   output logic [28:0]       ddram_addr,
   output logic [BEAT_W-1:0] ddram_din,
   output logic [BE_W-1:0]   ddram_be,
   output logic              ddram_we,
   input  logic              ddram_busy,
   output logic [23:0]       words_written,
   output logic              load_done
);

   ldr_state_e        state_q, state_d;
   logic [BEAT_W-1:0] buf_q, buf_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [23:0]       tag_q, tag_d;
   logic [28:0]       addr_q, addr_d;
   logic [23:0]       words_q, words_d;
   logic              done_q, done_d;
   logic              dl_prev_q;

   logic              active, strobe, busy_st;
   logic              skid_push, skid_pop, skid_valid;
   logic [26:0]       skid_addr;
   logic [LANE_W-1:0] skid_data;
   logic              in_valid;
   logic [26:0]       in_addr;
   logic [LANE_W-1:0] in_data;
   logic [23:0]       in_tag;
   logic [1:0]        in_lane;
   logic              unused_addr_lsb;

   assign active   = ioctl_download && (ioctl_index == ROM_INDEX);
   assign strobe   = ioctl_wr && active;
   assign busy_st  = (state_q == ST_WRITE) || (state_q == ST_FLUSH);

   // A parked skid entry takes priority over the live port when refilling the buffer.
   assign in_valid = skid_valid || strobe;
   assign in_addr  = skid_valid ? skid_addr : ioctl_addr;
   assign in_data  = skid_valid ? skid_data : ioctl_dout;
   assign in_tag   = in_addr[26:3];
   assign in_lane  = in_addr[2:1];
   assign unused_addr_lsb = in_addr[0];

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      be_d      = be_q;
      tag_d     = tag_q;
      addr_d    = addr_q;
      words_d   = words_q;
      done_d    = 1'b0;
      skid_push = 1'b0;
      skid_pop  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (active && !dl_prev_q) begin
               state_d = ST_COLLECT;
               buf_d   = '0;
               be_d    = '0;
               words_d = '0;
            end
         end

         ST_COLLECT: begin
            if (in_valid) begin
               if (!skid_valid && (be_q != '0) && (in_tag != tag_q)) begin
                  skid_push = 1'b1;
                  state_d   = ST_WRITE;
               end else begin
                  skid_pop = skid_valid;
                  tag_d    = in_tag;
                  addr_d   = BASE_ADDR + 29'(in_tag);
                  buf_d[{in_lane, 4'b0000} +: LANE_W] = in_data;
                  be_d     = be_q | lane_be(in_lane);
                  if (in_lane == 2'd3) begin
                     state_d = ST_WRITE;
                  end
               end
            end else if (!ioctl_download) begin
               if (be_q != '0) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_WRITE, ST_FLUSH: begin
            if (strobe && !skid_valid) begin
               skid_push = 1'b1;
            end
            if (!ddram_busy) begin
               if (words_q != 24'hFFFFFF) begin
                  words_d = words_q + 24'd1;
               end
               buf_d = '0;
               be_d  = '0;
               if (state_q == ST_FLUSH) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         buf_q     <= '0;
         be_q      <= '0;
         tag_q     <= '0;
         addr_q    <= '0;
         words_q   <= '0;
         done_q    <= 1'b0;
         dl_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         be_q      <= be_d;
         tag_q     <= tag_d;
         addr_q    <= addr_d;
         words_q   <= words_d;
         done_q    <= done_d;
         dl_prev_q <= ioctl_download;
      end
   end

   ioctl_skid u_skid (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .push      (skid_push),
      .pop       (skid_pop),
      .push_addr (ioctl_addr),
      .push_data (ioctl_dout),
      .valid     (skid_valid),
      .addr      (skid_addr),
      .data      (skid_data)
   );

   assign ioctl_wait    = busy_st || skid_valid;
   assign ddram_we      = busy_st;
   assign ddram_addr    = addr_q;
   assign ddram_din     = buf_q;
   assign ddram_be      = be_q;
   assign words_written = words_q;
   assign load_done     = done_q;

endmodule
